// File: rtl/async_receiver_pkg.sv
// Shared types and helpers for the async_receiver serial input block.
// The PARITY state exists only when RX_PARITY_EN is defined.
package async_receiver_pkg;

  localparam int ACC_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK_WAIT
  } rx_state_e;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/async_receiver_baud_tick_gen.sv
// Oversample tick generator: a free-running phase accumulator whose
// carry-out is a one-clk tick at Rate Hz.
module baud_tick_gen
  import async_receiver_pkg::*;
#(
  parameter int ClkFrequency = 100_000_000,
  parameter int Rate         = 153_600
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam longint IncFull =
    ((longint'(Rate) << ACC_WIDTH) + longint'(ClkFrequency / 2)) / longint'(ClkFrequency);
  localparam logic [ACC_WIDTH-1:0] Inc = ACC_WIDTH'(IncFull);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 tick_q, tick_d;

  always_comb begin
    {tick_d, acc_d} = {1'b0, acc_q} + {1'b0, Inc};
  end

  // NOTE: sequential state is written with <= only, so every flop samples
  // the pre-edge values of its neighbours regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/async_receiver.sv
// Oversampling UART receiver, 8N1 by default; define RX_PARITY_EN for 8E1
// with a parity-error pulse.
module async_receiver
  import async_receiver_pkg::*;
#(
  parameter int ClkFrequency = 100_000_000,
  parameter int Baud         = 9600,
  parameter int Oversampling = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_frame_err,
  output logic       RxD_parity_err,
  output logic       RxD_busy
);

  localparam int CntW = $clog2(Oversampling);
  localparam logic [CntW-1:0] SampA   = CntW'(Oversampling / 2 - 1);
  localparam logic [CntW-1:0] SampB   = CntW'(Oversampling / 2);
  localparam logic [CntW-1:0] SampC   = CntW'(Oversampling / 2 + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(Oversampling - 1);

  logic            tick;
  logic [1:0]      sync_q;
  logic            rx_s;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      samp_q, samp_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            ready_q, ready_d;
  logic            ferr_q, ferr_d;
  logic            maj, decide, bit_end;
`ifdef RX_PARITY_EN
  logic            par_q, par_d;
  logic            perr_q, perr_d;
`endif

  baud_tick_gen #(
    .ClkFrequency(ClkFrequency),
    .Rate        (Baud * Oversampling)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign rx_s    = sync_q[1];
  assign decide  = tick && (cnt_q == SampC);
  assign bit_end = tick && (cnt_q == CntLast);
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  // NOTE: every variable gets a default before the case statement so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    samp_d  = samp_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif

    if (state_q != S_IDLE && tick) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
      if (cnt_q == SampA) samp_d[0] = rx_s;
      if (cnt_q == SampB) samp_d[1] = rx_s;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (decide && maj) begin
          state_d = S_IDLE;
        end else if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (decide) shift_d = {maj, shift_q[7:1]};
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
`ifdef RX_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (decide)  par_d   = maj;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Decide mid-stop-bit so the next start edge is never missed.
        if (decide) begin
          if (maj) begin
            state_d = S_IDLE;
`ifdef RX_PARITY_EN
            if (par_q != even_parity(shift_q)) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              ready_d = 1'b1;
            end
`else
            data_d  = shift_q;
            ready_d = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK_WAIT;
          end
        end
      end
      S_BREAK_WAIT: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      samp_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], RxD};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      samp_q  <= samp_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end
  assign RxD_parity_err = perr_q;
`else
  assign RxD_parity_err = 1'b0;
`endif

  assign RxD_data       = data_q;
  assign RxD_data_ready = ready_q;
  assign RxD_frame_err  = ferr_q;
  assign RxD_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_async_receiver.sv
// Scoreboard bench for async_receiver at 100 MHz / 115200 baud / x16.
// Define RX_PARITY_EN for both DUT and bench to exercise the 8E1 build.
module tb_async_receiver;

  localparam int  ClkFrequency = 100_000_000;
  localparam int  Baud         = 115_200;
  localparam real BitNs        = 1.0e9 / 115200.0;

  typedef enum int {EV_DATA = 0, EV_FRAME = 1, EV_PARITY = 2} ev_e;
  typedef struct {
    ev_e        kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RxD = 1'b1;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       RxD_frame_err;
  logic       RxD_parity_err;
  logic       RxD_busy;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  async_receiver #(
    .ClkFrequency(ClkFrequency),
    .Baud        (Baud),
    .Oversampling(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .RxD           (RxD),
    .RxD_data      (RxD_data),
    .RxD_data_ready(RxD_data_ready),
    .RxD_frame_err (RxD_frame_err),
    .RxD_parity_err(RxD_parity_err),
    .RxD_busy      (RxD_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input ev_e kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input real bit_ns, input logic stop,
                            input logic par_flip);
    RxD = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      #(bit_ns);
    end
`ifdef RX_PARITY_EN
    RxD = (^d) ^ par_flip;
    #(bit_ns);
`else
    if (par_flip) $display("note: parity flip has no effect in the 8N1 build");
`endif
    RxD = stop;
    #(bit_ns);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check(tag, sb.size(), 0);
    @(negedge clk);
  endtask

  // Output monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (RxD_data_ready || RxD_frame_err || RxD_parity_err)) begin
      int   n_pulse;
      ev_e  got;
      exp_t e;
      n_pulse = int'(RxD_data_ready) + int'(RxD_frame_err) + int'(RxD_parity_err);
      check("one_pulse", n_pulse, 1);
      got = RxD_data_ready ? EV_DATA : (RxD_frame_err ? EV_FRAME : EV_PARITY);
      if (sb.size() == 0) begin
        check("unexpected_pulse", int'(got) + 1, 0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", int'(got), int'(e.kind));
        if (e.kind == EV_DATA) check("rx_data", RxD_data, e.data);
      end
    end
  end

  initial begin
    #1_100_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (5) @(negedge clk);
    check("rst_data", RxD_data, 8'h00);
    check("rst_ready", RxD_data_ready, 0);
    check("rst_ferr", RxD_frame_err, 0);
    check("rst_perr", RxD_parity_err, 0);
    check("rst_busy", RxD_busy, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Plain frame
    push(EV_DATA, 8'h55);
    send_frame(8'h55, BitNs, 1'b1, 1'b0);
    wait_drain("drain_55");
    check("busy_after_55", RxD_busy, 0);
    check("data_after_55", RxD_data, 8'h55);

    // Short low glitch must be rejected
    RxD = 1'b0;
    repeat (200) @(posedge clk);
    RxD = 1'b1;
    #(BitNs);
    @(negedge clk);
    check("glitch_busy", RxD_busy, 0);
    check("glitch_data", RxD_data, 8'h55);

    // Framing error followed by a long break
    push(EV_FRAME, 8'h00);
    send_frame(8'hA3, BitNs, 1'b0, 1'b0);
    wait_drain("drain_ferr");
    #(19.0 * BitNs);
    @(negedge clk);
    check("break_busy", RxD_busy, 1);
    check("break_data", RxD_data, 8'h55);
    RxD = 1'b1;
    #(BitNs);
    @(negedge clk);
    check("break_exit_busy", RxD_busy, 0);
    push(EV_DATA, 8'h3C);
    send_frame(8'h3C, BitNs, 1'b1, 1'b0);
    wait_drain("drain_3c");
    check("data_after_3c", RxD_data, 8'h3C);

    // Back-to-back frames from a transmitter running 2% fast
    push(EV_DATA, 8'h00);
    push(EV_DATA, 8'hFF);
    send_frame(8'h00, BitNs / 1.02, 1'b1, 1'b0);
    send_frame(8'hFF, BitNs / 1.02, 1'b1, 1'b0);
    wait_drain("drain_b2b");
    check("data_after_b2b", RxD_data, 8'hFF);

    // Reset in the middle of a frame (after data bit 3 of 0x81)
    RxD = 1'b0;
    #(BitNs);
    for (int i = 0; i < 4; i++) begin
      RxD = (8'h81 >> i) & 8'h01;
      #(BitNs);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_data", RxD_data, 8'h00);
    check("midrst_ready", RxD_data_ready, 0);
    check("midrst_ferr", RxD_frame_err, 0);
    check("midrst_perr", RxD_parity_err, 0);
    check("midrst_busy", RxD_busy, 0);
    RxD = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    #(BitNs);
    push(EV_DATA, 8'h81);
    send_frame(8'h81, BitNs, 1'b1, 1'b0);
    wait_drain("drain_81");
    check("data_after_81", RxD_data, 8'h81);
    check("busy_after_81", RxD_busy, 0);

`ifdef RX_PARITY_EN
    // Bad parity is reported in place of data; good parity delivers the byte
    push(EV_PARITY, 8'h00);
    send_frame(8'h07, BitNs, 1'b1, 1'b1);
    wait_drain("drain_perr");
    check("data_after_perr", RxD_data, 8'h81);
    push(EV_DATA, 8'h07);
    send_frame(8'h07, BitNs, 1'b1, 1'b0);
    wait_drain("drain_07");
    check("data_after_07", RxD_data, 8'h07);
`endif

    repeat (20) @(negedge clk);
    check("sb_empty_end", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
